wb_stage: RTL and testbench

// - Writeback stage directly upstream of the scalar register file. Merges ALU results and load-unit results onto the single register-file write port.
// - Aligns and sign- or zero-extends load data.
// - Buffers load results that lose arbitration to the ALU.
// - Exports a pending-destination mask so decode can stall on RAW hazards.

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_load_fifo.sv | 74 +++++++
 rtl/wb_stage.sv | 115 +++++++++++
 tb/tb_wb_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and the load-extension helper for the writeback stage.
package wb_pkg;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } load_type_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // Byte lanes come from the word offset; halfwords only from off[1].
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (load_type_e'(funct3))
            LD_B:    return {{24{b[7]}}, b};
            LD_BU:   return {24'h0, b};
            LD_H:    return {{16{h[15]}}, h};
            LD_HU:   return {16'h0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load-result FIFO; exposes per-entry valid/rd so the stage can build its hazard mask.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  wb_entry_t             push_entry_i,
    input  logic                  pop_i,
    output wb_entry_t             head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH-1:0]      vld_o,
    output logic [DEPTH-1:0][4:0] rd_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign vld_o   = vld_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_o[i] = mem_q[i].rd;
        end
    end

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        mem_d    = mem_q;
        if (do_pop) begin
            vld_d[rd_ptr_q[AW-1:0]] = 1'b0;
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_entry_i;
            vld_d[wr_ptr_q[AW-1:0]] = 1'b1;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU and queued load results onto the register-file write port.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid_i,
    input  logic [4:0]            alu_rd_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    output logic                  alu_stall_o,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [4:0]            lsu_rd_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    input  logic [2:0]            lsu_funct3_i,
    input  logic [1:0]            lsu_off_i,
    output logic                  reg_write_o,
    output logic [4:0]            rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [31:0]           pend_mask_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]           starve_q, starve_d;
    logic                    reg_write_q, reg_write_d;
    logic [4:0]              rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    fifo_full, fifo_empty;
    logic                    push, pop, starved, alu_win;
    wb_entry_t               push_entry, head;
    logic [LQ_DEPTH-1:0]     ent_vld;
    logic [LQ_DEPTH-1:0][4:0] ent_rd;
    logic [31:0]             pend_mask;

    assign lsu_ready_o      = !fifo_full;
    // Loads to x0 complete the handshake but never occupy a slot.
    assign push             = lsu_valid_i && lsu_ready_o && (lsu_rd_i != 5'd0);
    assign push_entry.rd    = lsu_rd_i;
    assign push_entry.data  = load_extend(lsu_data_i, lsu_funct3_i, lsu_off_i);

    assign starved     = !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
    assign alu_win     = alu_valid_i && !starved;
    assign pop         = !alu_win && !fifo_empty;
    assign alu_stall_o = alu_valid_i && !alu_win;

    wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .vld_o        (ent_vld),
        .rd_o         (ent_rd)
    );

    always_comb begin
        reg_write_d = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        starve_d    = starve_q;
        if (alu_win) begin
            if (alu_rd_i != 5'd0) begin
                reg_write_d = 1'b1;
                rd_addr_d   = alu_rd_i;
                rd_data_d   = alu_data_i;
            end
        end else if (pop) begin
            reg_write_d = 1'b1;
            rd_addr_d   = head.rd;
            rd_data_d   = head.data;
        end
        // Counter only measures how long the current head has been waiting.
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (alu_win && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            starve_q    <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            starve_q    <= starve_d;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (ent_vld[i]) pend_mask[ent_rd[i]] = 1'b1;
        end
        if (reg_write_q) pend_mask[rd_addr_q] = 1'b1;
        pend_mask[0] = 1'b0;
    end

    assign reg_write_o = reg_write_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_data_o   = rd_data_q;
    assign pend_mask_o = pend_mask;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: latency, extension, arbitration, starvation, x0 handling and reset.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        alu_stall_o;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic [2:0]  lsu_funct3_i;
    logic [1:0]  lsu_off_i;
    logic        reg_write_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [31:0] pend_mask_o;

    int n_cmp = 0;
    int n_err = 0;

    wb_stage #(.DATA_WIDTH(32), .LQ_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid_i  (alu_valid_i),
        .alu_rd_i     (alu_rd_i),
        .alu_data_i   (alu_data_i),
        .alu_stall_o  (alu_stall_o),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_rd_i     (lsu_rd_i),
        .lsu_data_i   (lsu_data_i),
        .lsu_funct3_i (lsu_funct3_i),
        .lsu_off_i    (lsu_off_i),
        .reg_write_o  (reg_write_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .pend_mask_o  (pend_mask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid_i  = 1'b0;
        alu_rd_i     = 5'd0;
        alu_data_i   = 32'h0;
        lsu_valid_i  = 1'b0;
        lsu_rd_i     = 5'd0;
        lsu_data_i   = 32'h0;
        lsu_funct3_i = 3'b010;
        lsu_off_i    = 2'd0;
    endtask

    logic [2:0]  ext_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ext_off [5] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [31:0] ext_exp [5] = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

    int          arb_rd    [7] = '{20, 21, 22, 23, 24, 11, 25};
    logic        arb_ready [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        arb_stall [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int a;
        int l;
        logic acc;
        logic adv;

        idle();
        rst = 1'b1;
        #3;
        chk("reset_reg_write", 32'(reg_write_o), 32'd0);
        chk("reset_rd_addr",   32'(rd_addr_o),   32'd0);
        chk("reset_rd_data",   rd_data_o,        32'd0);
        chk("reset_pend",      pend_mask_o,      32'd0);
        chk("reset_ready",     32'(lsu_ready_o), 32'd1);
        chk("reset_stall",     32'(alu_stall_o), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ALU write latency and mask lifetime
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h12345678;
        #1;
        chk("alu_stall",       32'(alu_stall_o), 32'd0);
        chk("alu_pend_n",      pend_mask_o,      32'd0);
        tick();
        idle();
        chk("alu_we",          32'(reg_write_o), 32'd1);
        chk("alu_addr",        32'(rd_addr_o),   32'd5);
        chk("alu_data",        rd_data_o,        32'h12345678);
        chk("alu_pend_n1",     pend_mask_o,      32'h00000020);
        tick();
        chk("alu_we_n2",       32'(reg_write_o), 32'd0);
        chk("alu_pend_n2",     pend_mask_o,      32'd0);
        chk("alu_addr_hold",   32'(rd_addr_o),   32'd5);

        // Load extension, two-cycle latency
        for (int k = 0; k < 5; k++) begin
            lsu_valid_i = 1'b1; lsu_rd_i = 5'(8 + k); lsu_data_i = 32'h80FF7F01;
            lsu_funct3_i = ext_f3[k]; lsu_off_i = ext_off[k];
            #1;
            chk($sformatf("ext%0d_ready", k), 32'(lsu_ready_o), 32'd1);
            tick();
            idle();
            chk($sformatf("ext%0d_we_n1", k), 32'(reg_write_o), 32'd0);
            chk($sformatf("ext%0d_pend_n1", k), pend_mask_o, 32'd1 << (8 + k));
            tick();
            chk($sformatf("ext%0d_we_n2", k), 32'(reg_write_o), 32'd1);
            chk($sformatf("ext%0d_addr", k), 32'(rd_addr_o), 32'(8 + k));
            chk($sformatf("ext%0d_data", k), rd_data_o, ext_exp[k]);
        end
        tick();

        // Simultaneous ALU and load
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h00000111;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd2; lsu_data_i = 32'h00000042; lsu_funct3_i = 3'b010;
        tick();
        idle();
        chk("sim_n1_addr", 32'(rd_addr_o), 32'd1);
        chk("sim_n1_data", rd_data_o,      32'h00000111);
        chk("sim_n1_pend", pend_mask_o,    32'h00000006);
        tick();
        chk("sim_n2_we",   32'(reg_write_o), 32'd1);
        chk("sim_n2_addr", 32'(rd_addr_o),   32'd2);
        chk("sim_n2_data", rd_data_o,        32'h00000042);
        chk("sim_n2_pend", pend_mask_o,      32'h00000004);
        tick();
        chk("sim_n3_we",   32'(reg_write_o), 32'd0);

        // Starvation: ALU valid every cycle, three loads offered
        a = 0;
        l = 0;
        for (int c = 0; c < 7; c++) begin
            alu_valid_i = 1'b1; alu_rd_i = 5'(20 + a); alu_data_i = 32'h000000A0 + 32'(a);
            lsu_valid_i = (l < 3); lsu_rd_i = 5'(11 + l); lsu_data_i = 32'h00000100 + 32'(11 + l);
            lsu_funct3_i = 3'b010; lsu_off_i = 2'd0;
            #1;
            chk($sformatf("arb%0d_ready", c), 32'(lsu_ready_o), 32'(arb_ready[c]));
            chk($sformatf("arb%0d_stall", c), 32'(alu_stall_o), 32'(arb_stall[c]));
            acc = lsu_valid_i && lsu_ready_o;
            adv = !alu_stall_o;
            tick();
            chk($sformatf("arb%0d_we", c), 32'(reg_write_o), 32'd1);
            chk($sformatf("arb%0d_addr", c), 32'(rd_addr_o), 32'(arb_rd[c]));
            if (c == 2) chk("arb2_pend", pend_mask_o, (32'd1 << 11) | (32'd1 << 12) | (32'd1 << 22));
            if (c == 5) chk("arb5_data", rd_data_o, 32'h0000010B);
            if (c == 6) chk("arb6_data", rd_data_o, 32'h000000A5);
            if (acc) l++;
            if (adv) a++;
        end
        idle();
        tick();
        chk("drain0_addr", 32'(rd_addr_o), 32'd12);
        chk("drain0_data", rd_data_o,      32'h0000010C);
        tick();
        chk("drain1_addr", 32'(rd_addr_o), 32'd13);
        chk("drain1_data", rd_data_o,      32'h0000010D);
        tick();
        chk("drain_done_we",   32'(reg_write_o), 32'd0);
        chk("drain_done_pend", pend_mask_o,      32'd0);

        // x0 on both sources
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hDEADBEEF;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd0; lsu_data_i = 32'hCAFEF00D;
        #1;
        chk("x0_ready", 32'(lsu_ready_o), 32'd1);
        chk("x0_stall", 32'(alu_stall_o), 32'd0);
        tick();
        idle();
        chk("x0_we_n1",   32'(reg_write_o), 32'd0);
        chk("x0_pend_n1", pend_mask_o,      32'd0);
        tick();
        chk("x0_we_n2",   32'(reg_write_o), 32'd0);
        chk("x0_pend_n2", pend_mask_o,      32'd0);

        // Asynchronous reset with two loads queued
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h33;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd14; lsu_data_i = 32'h14;
        tick();
        alu_rd_i = 5'd4; alu_data_i = 32'h44;
        lsu_rd_i = 5'd15; lsu_data_i = 32'h15;
        tick();
        idle();
        #1;
        chk("pre_rst_we",   32'(reg_write_o), 32'd1);
        chk("pre_rst_full", 32'(lsu_ready_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_we",    32'(reg_write_o), 32'd0);
        chk("rst_addr",  32'(rd_addr_o),   32'd0);
        chk("rst_data",  rd_data_o,        32'd0);
        chk("rst_pend",  pend_mask_o,      32'd0);
        chk("rst_ready", 32'(lsu_ready_o), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h00000777;
        tick();
        idle();
        chk("post_rst_we",   32'(reg_write_o), 32'd1);
        chk("post_rst_addr", 32'(rd_addr_o),   32'd7);
        chk("post_rst_data", rd_data_o,        32'h00000777);
        tick();
        chk("post_rst_empty_we",   32'(reg_write_o), 32'd0);
        chk("post_rst_empty_pend", pend_mask_o,      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
